// File: rtl/adventure_move_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : adventure_move_sequencer
//  Description : Scripted player for the adventure_game FSM. Holds a loadable
//                move script, pulses the game reset, then issues one move per
//                FETCH/DRIVE/CHECK step and ends the run on WIN, DIE, an
//                end-of-script marker or the last script entry.
//  Options     : ADV_SEQ_ONEHOT_CHECK_EN - abort the run with err=1 on script
//                entries that are neither one-hot, 4'b0000 nor 4'b1111.
//  Revision    : 1.0 - initial release
// ============================================================================
module adventure_move_sequencer #(
   parameter int DEPTH      = 16,
   parameter int AW         = 4,
   parameter int RST_CYCLES = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [3:0]    wr_data,
   input  logic          start,
   input  logic          WIN,
   input  logic          DIE,
   output logic          game_reset,
   output logic          N,
   output logic          S,
   output logic          E,
   output logic          W,
   output logic          busy,
   output logic          done,
   output logic [1:0]    result,
   output logic [AW:0]   move_count,
   output logic          err
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_GRST   = 3'd1;
   localparam logic [2:0] S_FETCH  = 3'd2;
   localparam logic [2:0] S_DRIVE  = 3'd3;
   localparam logic [2:0] S_CHECK  = 3'd4;
   localparam logic [2:0] S_FINISH = 3'd5;

   localparam logic [1:0] RES_NONE = 2'b00;
   localparam logic [1:0] RES_WIN  = 2'b01;
   localparam logic [1:0] RES_DIE  = 2'b10;
   localparam logic [1:0] RES_END  = 2'b11;

   localparam logic [3:0] END_MARK = 4'b1111;

   // Counter wide enough to hold RST_CYCLES-1
   localparam int CW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam logic [CW-1:0] GRST_LAST = CW'(RST_CYCLES - 1);
   localparam logic [AW-1:0] PTR_LAST  = AW'(DEPTH - 1);

   logic [3:0]    mem_q [DEPTH];

   logic [2:0]    state_q, state_d;
   logic [AW-1:0] ptr_q, ptr_d;
   logic [3:0]    entry_q, entry_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    result_q, result_d;
   logic [AW:0]   move_count_q, move_count_d;

   logic [3:0]    mem_rd;

   assign mem_rd = mem_q[ptr_q];

`ifdef ADV_SEQ_ONEHOT_CHECK_EN
   logic err_q, err_d;
   logic illegal_entry;

   // Anything with two or three direction bits set cannot be a real move
   assign illegal_entry = (mem_rd != 4'b0000) && ($countones(mem_rd) != 1);
   assign err           = err_q;
`else
   assign err = 1'b0;
`endif

   // Script storage: writable only while no run is in progress, never reset
   always_ff @(posedge clk) begin
      if (wr_en && !busy) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   // Run sequencing: next-state and result bookkeeping
   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      entry_d      = entry_q;
      cnt_d        = cnt_q;
      result_d     = result_q;
      move_count_d = move_count_q;
`ifdef ADV_SEQ_ONEHOT_CHECK_EN
      err_d        = err_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               result_d     = RES_NONE;
               move_count_d = '0;
               ptr_d        = '0;
               cnt_d        = '0;
`ifdef ADV_SEQ_ONEHOT_CHECK_EN
               err_d        = 1'b0;
`endif
               state_d      = S_GRST;
            end
         end
         S_GRST: begin
            if (cnt_q == GRST_LAST) begin
               state_d = S_FETCH;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_FETCH: begin
            if (mem_rd == END_MARK) begin
               result_d = RES_END;
               state_d  = S_FINISH;
`ifdef ADV_SEQ_ONEHOT_CHECK_EN
            end else if (illegal_entry) begin
               result_d = RES_END;
               err_d    = 1'b1;
               state_d  = S_FINISH;
`endif
            end else begin
               entry_d = mem_rd;
               state_d = S_DRIVE;
            end
         end
         S_DRIVE: begin
            move_count_d = move_count_q + (AW+1)'(1);
            state_d      = S_CHECK;
         end
         S_CHECK: begin
            // DIE takes priority when the game reports both
            if (DIE) begin
               result_d = RES_DIE;
               state_d  = S_FINISH;
            end else if (WIN) begin
               result_d = RES_WIN;
               state_d  = S_FINISH;
            end else if (ptr_q == PTR_LAST) begin
               result_d = RES_END;
               state_d  = S_FINISH;
            end else begin
               ptr_d   = ptr_q + AW'(1);
               state_d = S_FETCH;
            end
         end
         S_FINISH: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State registers with synchronous reset; reset mid-run aborts silently
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         ptr_q        <= '0;
         entry_q      <= '0;
         cnt_q        <= '0;
         result_q     <= RES_NONE;
         move_count_q <= '0;
`ifdef ADV_SEQ_ONEHOT_CHECK_EN
         err_q        <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         entry_q      <= entry_d;
         cnt_q        <= cnt_d;
         result_q     <= result_d;
         move_count_q <= move_count_d;
`ifdef ADV_SEQ_ONEHOT_CHECK_EN
         err_q        <= err_d;
`endif
      end
   end

   // Outputs decoded from state so directions and game_reset cannot leak
   // outside their own states
   assign game_reset   = (state_q == S_GRST);
   assign {N, S, E, W} = (state_q == S_DRIVE) ? entry_q : 4'b0000;
   assign busy         = (state_q == S_GRST) || (state_q == S_FETCH) ||
                         (state_q == S_DRIVE) || (state_q == S_CHECK);
   assign done         = (state_q == S_FINISH);
   assign result       = result_q;
   assign move_count   = move_count_q;

endmodule
`default_nettype wire

// File: tb/tb_adventure_move_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adventure_move_sequencer
//  Description : Directed self-checking bench for adventure_move_sequencer
//                with a tiny game model that raises WIN/DIE after a chosen
//                number of visible moves.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_adventure_move_sequencer;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       wr_en = 1'b0;
   logic [3:0] wr_addr = '0;
   logic [3:0] wr_data = '0;
   logic       start = 1'b0;
   logic       WIN, DIE;
   logic       game_reset, N, S, E, W, busy, done, err;
   logic [1:0] result;
   logic [4:0] move_count;

   int vectors    = 0;
   int miscompares = 0;

   // game model state, owned by the negedge monitor
   int tb_moves   = 0;
   int gr_cycles  = 0;
   int c1010      = 0;
   int outside    = 0;
   int win_at     = -1;
   int die_at     = -1;

   assign WIN = (tb_moves == win_at);
   assign DIE = (tb_moves == die_at);

   always #5 clk = ~clk;

   adventure_move_sequencer #(.DEPTH(16), .AW(4), .RST_CYCLES(2)) dut (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .start(start), .WIN(WIN), .DIE(DIE),
      .game_reset(game_reset), .N(N), .S(S), .E(E), .W(W),
      .busy(busy), .done(done), .result(result), .move_count(move_count),
      .err(err)
   );

   // Game model and activity monitor, sampled mid-cycle
   always @(negedge clk) begin
      if ({N, S, E, W} != 4'b0000) begin
         tb_moves++;
         if ({N, S, E, W} == 4'b1010) c1010++;
         if (!busy) outside++;
      end
      if (game_reset) gr_cycles++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input int a, input logic [3:0] d);
      wr_addr = a[3:0];
      wr_data = d;
      wr_en   = 1'b1;
      tick();
      wr_en   = 1'b0;
   endtask

   // Pulse start and wait (bounded) for done; lat counts edges after the start edge
   task automatic run(output int lat, output bit to);
      start = 1'b1;
      tick();
      start = 1'b0;
      lat = 0;
      to  = 1'b0;
      while (!done && !to) begin
         tick();
         lat++;
         if (lat > 200) to = 1'b1;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      vectors++;
      if ({game_reset, N, S, E, W, busy, done, err} !== 8'b0) begin
         miscompares++;
         $display("FAIL reset_flags: got %b want 00000000", {game_reset, N, S, E, W, busy, done, err});
      end
      vectors++;
      if (result !== 2'b00) begin
         miscompares++;
         $display("FAIL reset_result: got %b want 00", result);
      end
      vectors++;
      if (move_count !== 5'd0) begin
         miscompares++;
         $display("FAIL reset_move_count: got %0d want 0", move_count);
      end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_win_path();
      int lat; bit to; int g0, m0;
      load(0, 4'b0001); load(1, 4'b0001); load(2, 4'b1000); load(3, 4'b1111);
      g0 = gr_cycles; m0 = tb_moves;
      die_at = -1; win_at = tb_moves + 3;
      run(lat, to);
      vectors++;
      if (to !== 1'b0) begin miscompares++; $display("FAIL win_timeout: got %0d want 0", to); end
      vectors++;
      if (lat != 11) begin miscompares++; $display("FAIL win_latency: got %0d want 11", lat); end
      vectors++;
      if (result !== 2'b01) begin miscompares++; $display("FAIL win_result: got %b want 01", result); end
      vectors++;
      if (move_count !== 5'd3) begin miscompares++; $display("FAIL win_move_count: got %0d want 3", move_count); end
      vectors++;
      if (busy !== 1'b0) begin miscompares++; $display("FAIL win_busy_at_done: got %b want 0", busy); end
      vectors++;
      if (gr_cycles - g0 != 2) begin miscompares++; $display("FAIL win_grst_cycles: got %0d want 2", gr_cycles - g0); end
      vectors++;
      if (tb_moves - m0 != 3) begin miscompares++; $display("FAIL win_dir_pulses: got %0d want 3", tb_moves - m0); end
      // start coinciding with FINISH->IDLE must be ignored
      start = 1'b1;
      tick();
      start = 1'b0;
      vectors++;
      if ({busy, done} !== 2'b00) begin miscompares++; $display("FAIL win_start_at_finish: got %b want 00", {busy, done}); end
      vectors++;
      if (result !== 2'b01 || move_count !== 5'd3) begin
         miscompares++;
         $display("FAIL win_hold: got %b/%0d want 01/3", result, move_count);
      end
      tick();
      vectors++;
      if (busy !== 1'b0) begin miscompares++; $display("FAIL win_stays_idle: got %b want 0", busy); end
      win_at = -1;
   endtask

   task automatic test_die_path();
      int lat; bit to; int m0;
      load(0, 4'b0100); load(1, 4'b0001); load(2, 4'b1000); load(3, 4'b1111);
      m0 = tb_moves;
      win_at = -1; die_at = tb_moves + 1;
      run(lat, to);
      vectors++;
      if (to || lat != 5) begin miscompares++; $display("FAIL die_latency: got %0d want 5", lat); end
      vectors++;
      if (result !== 2'b10) begin miscompares++; $display("FAIL die_result: got %b want 10", result); end
      vectors++;
      if (move_count !== 5'd1) begin miscompares++; $display("FAIL die_move_count: got %0d want 1", move_count); end
      for (int i = 0; i < 10; i++) tick();
      vectors++;
      if (tb_moves - m0 != 1) begin miscompares++; $display("FAIL die_no_more_dirs: got %0d want 1", tb_moves - m0); end
      die_at = -1;
   endtask

   task automatic test_marker_idle_step();
      int lat; bit to; int m0;
      load(0, 4'b1000); load(1, 4'b0000); load(2, 4'b0010); load(3, 4'b1111);
      m0 = tb_moves;
      run(lat, to);
      vectors++;
      if (to || lat != 12) begin miscompares++; $display("FAIL marker_latency: got %0d want 12", lat); end
      vectors++;
      if (result !== 2'b11) begin miscompares++; $display("FAIL marker_result: got %b want 11", result); end
      vectors++;
      if (move_count !== 5'd3) begin miscompares++; $display("FAIL marker_move_count: got %0d want 3", move_count); end
      vectors++;
      if (tb_moves - m0 != 2) begin miscompares++; $display("FAIL marker_dir_pulses: got %0d want 2", tb_moves - m0); end
      tick();
   endtask

   task automatic test_full_script();
      int lat; bit to; int m0;
      for (int i = 0; i < 16; i++) load(i, 4'b0001);
      m0 = tb_moves;
      run(lat, to);
      vectors++;
      if (to || lat != 50) begin miscompares++; $display("FAIL full_latency: got %0d want 50", lat); end
      vectors++;
      if (result !== 2'b11) begin miscompares++; $display("FAIL full_result: got %b want 11", result); end
      vectors++;
      if (move_count !== 5'd16) begin miscompares++; $display("FAIL full_move_count: got %0d want 16", move_count); end
      vectors++;
      if (tb_moves - m0 != 16) begin miscompares++; $display("FAIL full_dir_pulses: got %0d want 16", tb_moves - m0); end
      tick();
   endtask

   task automatic test_both_high();
      int lat; bit to;
      load(0, 4'b0010); load(1, 4'b1111);
      win_at = tb_moves + 1; die_at = tb_moves + 1;
      run(lat, to);
      vectors++;
      if (to || lat != 5) begin miscompares++; $display("FAIL both_latency: got %0d want 5", lat); end
      vectors++;
      if (result !== 2'b10) begin miscompares++; $display("FAIL both_result: got %b want 10", result); end
      win_at = -1; die_at = -1;
      tick();
   endtask

   task automatic test_busy_ignored();
      int lat; bit to;
      load(0, 4'b0001); load(1, 4'b1111); load(2, 4'b1111);
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      wr_addr = 4'd1; wr_data = 4'b0010; wr_en = 1'b1; start = 1'b1;
      tick();
      wr_en = 1'b0; start = 1'b0;
      lat = 2; to = 1'b0;
      while (!done && !to) begin
         tick();
         lat++;
         if (lat > 200) to = 1'b1;
      end
      vectors++;
      if (to || lat != 6) begin miscompares++; $display("FAIL busy_latency: got %0d want 6", lat); end
      vectors++;
      if (move_count !== 5'd1 || result !== 2'b11) begin
         miscompares++;
         $display("FAIL busy_outcome: got %0d/%b want 1/11", move_count, result);
      end
      tick();
      run(lat, to);
      vectors++;
      if (to || lat != 6 || move_count !== 5'd1) begin
         miscompares++;
         $display("FAIL busy_write_dropped: got lat %0d mc %0d want lat 6 mc 1", lat, move_count);
      end
      tick();
   endtask

   task automatic test_reset_mid_run();
      int lat; bit to; int n; int dones;
      load(0, 4'b0001); load(1, 4'b0001); load(2, 4'b1111);
      start = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      while ({N, S, E, W} == 4'b0000 && n < 20) begin
         tick();
         n++;
      end
      vectors++;
      if (n >= 20) begin miscompares++; $display("FAIL midrst_reach_drive: got %0d want <20", n); end
      reset = 1'b1;
      tick();
      vectors++;
      if ({game_reset, N, S, E, W, busy, done, err} !== 8'b0 || result !== 2'b00 || move_count !== 5'd0) begin
         miscompares++;
         $display("FAIL midrst_outputs: got %b %b %0d want 0 0 0",
                  {game_reset, N, S, E, W, busy, done, err}, result, move_count);
      end
      reset = 1'b0;
      dones = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (done || busy) dones++;
      end
      vectors++;
      if (dones != 0) begin miscompares++; $display("FAIL midrst_no_done: got %0d want 0", dones); end
      run(lat, to);
      vectors++;
      if (to || lat != 9 || move_count !== 5'd2 || result !== 2'b11 || err !== 1'b0) begin
         miscompares++;
         $display("FAIL midrst_rerun: got lat %0d mc %0d res %b err %b want 9 2 11 0",
                  lat, move_count, result, err);
      end
      tick();
   endtask

   task automatic test_illegal_entry();
      int lat; bit to; int c0;
      load(0, 4'b0001); load(1, 4'b0001); load(2, 4'b1010); load(3, 4'b0010); load(4, 4'b1111);
      c0 = c1010;
      run(lat, to);
`ifdef ADV_SEQ_ONEHOT_CHECK_EN
      vectors++;
      if (to || lat != 9) begin miscompares++; $display("FAIL illegal_latency: got %0d want 9", lat); end
      vectors++;
      if (err !== 1'b1 || result !== 2'b11) begin
         miscompares++;
         $display("FAIL illegal_err: got err %b res %b want 1 11", err, result);
      end
      vectors++;
      if (move_count !== 5'd2) begin miscompares++; $display("FAIL illegal_move_count: got %0d want 2", move_count); end
      vectors++;
      if (c1010 - c0 != 0) begin miscompares++; $display("FAIL illegal_not_driven: got %0d want 0", c1010 - c0); end
`else
      vectors++;
      if (to || lat != 15) begin miscompares++; $display("FAIL illegal_latency: got %0d want 15", lat); end
      vectors++;
      if (err !== 1'b0 || result !== 2'b11) begin
         miscompares++;
         $display("FAIL illegal_err: got err %b res %b want 0 11", err, result);
      end
      vectors++;
      if (move_count !== 5'd4) begin miscompares++; $display("FAIL illegal_move_count: got %0d want 4", move_count); end
      vectors++;
      if (c1010 - c0 != 1) begin miscompares++; $display("FAIL illegal_driven_once: got %0d want 1", c1010 - c0); end
`endif
      tick();
   endtask

   initial begin
      test_reset();
      test_win_path();
      test_die_path();
      test_marker_idle_step();
      test_full_script();
      test_both_high();
      test_busy_ignored();
      test_reset_mid_run();
      test_illegal_entry();
      vectors++;
      if (outside != 0) begin miscompares++; $display("FAIL dirs_outside_busy: got %0d want 0", outside); end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
